// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants for the SPI frame sequencer: frame geometry, FSM encoding
// and the shadow-bank byte map seen by the stepgen/pwm/dout registers.
package spi_frame_ctrl_pkg;

  localparam int         FRAME_N     = 20;
  localparam int         SHADOW_AW   = 5;
  localparam logic [7:0] FRAME_MAGIC = 8'hA5;
  localparam int         ERR_CW      = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Payload byte positions: four 16-bit velocities, then dout, timing, pwm, spare.
  typedef enum logic [SHADOW_AW-1:0] {
    VEL0_LO = 5'd0,  VEL0_HI = 5'd1,  VEL1_LO = 5'd2,  VEL1_HI = 5'd3,
    VEL2_LO = 5'd4,  VEL2_HI = 5'd5,  VEL3_LO = 5'd6,  VEL3_HI = 5'd7,
    DOUT    = 5'd8,  TIMING  = 5'd10, PWM     = 5'd12, SPARE   = 5'd16
  } shadow_addr_e;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Byte-side inputs from the SPI shifter and register-bank side outputs.
interface spi_frame_ctrl_if
  import spi_frame_ctrl_pkg::*;
#(
  parameter int AW  = SHADOW_AW,
  parameter int ECW = ERR_CW
) ();
  logic           frame_start;
  logic           frame_end;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic           commit;
  logic           wdt_kick;
  logic           frame_err;
  logic [ECW-1:0] err_count;
  logic           busy;

  modport master (
    output frame_start, frame_end, byte_valid, byte_data,
    input  wr_en, wr_addr, wr_data, commit, wdt_kick, frame_err, err_count, busy
  );

  modport slave (
    input  frame_start, frame_end, byte_valid, byte_data,
    output wr_en, wr_addr, wr_data, commit, wdt_kick, frame_err, err_count, busy
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: validates header, length and XOR checksum of each SSEL frame,
// streams payload to the shadow bank and pulses commit/wdt_kick only on a good frame.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int         N     = FRAME_N,
  parameter int         AW    = SHADOW_AW,
  parameter logic [7:0] MAGIC = FRAME_MAGIC,
  parameter int         ECW   = ERR_CW
) (
  input logic              clk,
  input logic              rst_n,
  spi_frame_ctrl_if.slave  bus
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [2:0]     state, state_n;
  logic [AW-1:0]  idx, idx_n;
  logic [7:0]     sum, sum_n;
  logic           wr_n, commit_n, err_n;

  logic           wr_en, commit, frame_err, busy;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic [ECW-1:0] err_count;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    sum_n    = sum;
    wr_n     = 1'b0;
    commit_n = 1'b0;
    err_n    = 1'b0;

    // frame_end closes the current frame before any simultaneous frame_start reopens one
    if (bus.frame_end && state != S_IDLE) begin
      if (state == S_DONE) commit_n = 1'b1;
      else                 err_n    = 1'b1;
      state_n = S_IDLE;
    end else if (bus.frame_start && state != S_IDLE && state != S_DONE) begin
      err_n = 1'b1;
    end

    if (bus.frame_start) begin
      state_n = S_HDR;
      idx_n   = '0;
      sum_n   = '0;
    end else if (bus.byte_valid && !bus.frame_end) begin
      case (state)
        S_HDR:  state_n = (bus.byte_data == MAGIC) ? S_DATA : S_ERR;
        S_DATA: begin
          wr_n  = 1'b1;
          sum_n = sum ^ bus.byte_data;
          if (idx == LAST) state_n = S_SUM;
          else             idx_n   = idx + AW'(1);
        end
        S_SUM:  state_n = (bus.byte_data == sum) ? S_DONE : S_ERR;
        S_DONE: state_n = S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      sum       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sum       <= sum_n;
      wr_en     <= wr_n;
      commit    <= commit_n;
      frame_err <= err_n;
      busy      <= (state_n != S_IDLE);
      if (wr_n) begin
        wr_addr <= idx;
        wr_data <= bus.byte_data;
      end
      if (err_n && err_count != '1) err_count <= err_count + ECW'(1);
    end
  end

  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.commit    = commit;
  assign bus.wdt_kick  = commit;
  assign bus.frame_err = frame_err;
  assign bus.err_count = err_count;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: fixed vector table, directed frame sequences and
// randomized frames, all checked against a frame-level byte-queue model.
module tb_spi_frame_ctrl;
  import spi_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_frame_ctrl_if bus ();
  spi_frame_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 wr_en;
    logic [SHADOW_AW-1:0] wr_addr;
    logic [7:0]           wr_data;
    logic                 commit;
    logic                 wdt_kick;
    logic                 frame_err;
    logic [ERR_CW-1:0]    err_count;
    logic                 busy;
  } out_t;

  typedef struct {
    bit         fs, fe, bv;
    logic [7:0] bd;
    out_t       exp;
  } vec_t;

  typedef logic [7:0] bq_t[$];

  localparam int EMAX = (1 << ERR_CW) - 1;

  int   n_cmp = 0, n_bad = 0;
  int   n_wr, n_commit, n_err;
  bq_t  frame;
  bit   in_frame;
  int   ecnt;
  out_t mexp;

  function automatic out_t actual();
    out_t a;
    a.wr_en = bus.wr_en;   a.wr_addr = bus.wr_addr;   a.wr_data = bus.wr_data;
    a.commit = bus.commit; a.wdt_kick = bus.wdt_kick; a.frame_err = bus.frame_err;
    a.err_count = bus.err_count; a.busy = bus.busy;
    return a;
  endfunction

  function automatic out_t mk(bit we, int addr, int data, bit cm, bit fe, int ec, bit bz);
    out_t e;
    e.wr_en = we; e.wr_addr = SHADOW_AW'(addr); e.wr_data = 8'(data);
    e.commit = cm; e.wdt_kick = cm; e.frame_err = fe;
    e.err_count = ERR_CW'(ec); e.busy = bz;
    return e;
  endfunction

  task automatic check(input string tag, input out_t a, input out_t e);
    n_cmp++;
    // address/data are only meaningful while the strobe is high
    if (!e.wr_en) begin
      a.wr_addr = '0; a.wr_data = '0; e.wr_addr = '0; e.wr_data = '0;
    end
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, a, e);
    end
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // A frame is acceptable iff it is exactly header + N payload + checksum.
  function automatic bit good_frame();
    logic [7:0] x = 8'h00;
    if (frame.size() != FRAME_N + 2 || frame[0] !== FRAME_MAGIC) return 1'b0;
    for (int i = 1; i <= FRAME_N; i++) x ^= frame[i];
    return x == frame[FRAME_N + 1];
  endfunction

  task automatic cyc(input bit fs, input bit fe, input bit bv, input logic [7:0] bd,
                     input string tag);
    bit   err = 1'b0, com = 1'b0;
    out_t e = '0;
    out_t a;
    bus.frame_start = fs; bus.frame_end = fe; bus.byte_valid = bv; bus.byte_data = bd;
    if (fe) begin
      if (in_frame) begin
        if (good_frame()) com = 1'b1;
        else              err = 1'b1;
      end
      in_frame = 1'b0;
      frame.delete();
    end else if (fs && in_frame && !good_frame()) begin
      err = 1'b1;
    end
    if (fs) begin
      in_frame = 1'b1;
      frame.delete();
    end else if (bv && !fe && in_frame) begin
      frame.push_back(bd);
      if (frame[0] == FRAME_MAGIC && frame.size() >= 2 && frame.size() <= FRAME_N + 1) begin
        e.wr_en   = 1'b1;
        e.wr_addr = SHADOW_AW'(frame.size() - 2);
        e.wr_data = bd;
      end
    end
    if (err && ecnt < EMAX) ecnt++;
    e.commit = com; e.wdt_kick = com; e.frame_err = err;
    e.err_count = ERR_CW'(ecnt); e.busy = in_frame;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    a = actual();
    n_wr += int'(a.wr_en); n_commit += int'(a.commit); n_err += int'(a.frame_err);
    check(tag, a, e);
    mexp = e;
  endtask

  function automatic bq_t mk_good(input bit rnd);
    bq_t q;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    q.push_back(FRAME_MAGIC);
    for (int i = 1; i <= FRAME_N; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      x ^= b;
      q.push_back(b);
    end
    q.push_back(x);
    return q;
  endfunction

  task automatic send(input bq_t q, input int maxgap, input string tag);
    foreach (q[i]) begin
      repeat ($urandom_range(0, maxgap)) cyc(0, 0, 0, 8'h00, tag);
      cyc(0, 0, 1, q[i], tag);
    end
  endtask

  task automatic frame_tx(input bq_t q, input string tag);
    cyc(1, 0, 0, 8'h00, tag);
    send(q, 0, tag);
    cyc(0, 1, 0, 8'h00, tag);
    cyc(0, 0, 0, 8'h00, tag);
  endtask

  task automatic clr_counts();
    n_wr = 0; n_commit = 0; n_err = 0;
  endtask

  vec_t tbl[12];
  bq_t  q;

  initial begin
    bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    in_frame = 1'b0; ecnt = 0; clr_counts();

    tbl[0]  = '{0, 0, 1, 8'hA5, mk(0, 0, 0,    0, 0, 0, 0)};
    tbl[1]  = '{0, 1, 0, 8'h00, mk(0, 0, 0,    0, 0, 0, 0)};
    tbl[2]  = '{1, 0, 0, 8'h00, mk(0, 0, 0,    0, 0, 0, 1)};
    tbl[3]  = '{0, 0, 1, 8'hA5, mk(0, 0, 0,    0, 0, 0, 1)};
    tbl[4]  = '{0, 0, 1, 8'h01, mk(1, 0, 8'h01, 0, 0, 0, 1)};
    tbl[5]  = '{0, 0, 1, 8'h02, mk(1, 1, 8'h02, 0, 0, 0, 1)};
    tbl[6]  = '{0, 1, 1, 8'h03, mk(0, 0, 0,    0, 1, 1, 0)};
    tbl[7]  = '{1, 1, 0, 8'h00, mk(0, 0, 0,    0, 0, 1, 1)};
    tbl[8]  = '{0, 0, 1, 8'h5A, mk(0, 0, 0,    0, 0, 1, 1)};
    tbl[9]  = '{0, 0, 1, 8'h01, mk(0, 0, 0,    0, 0, 1, 1)};
    tbl[10] = '{1, 0, 0, 8'h00, mk(0, 0, 0,    0, 1, 2, 1)};
    tbl[11] = '{0, 1, 0, 8'h00, mk(0, 0, 0,    0, 1, 3, 0)};

    #12;
    check("reset_state", actual(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].fs, tbl[i].fe, tbl[i].bv, tbl[i].bd, $sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d", i), actual(), tbl[i].exp);
    end

    clr_counts();
    frame_tx(mk_good(0), "good");
    chk_int("good_writes", n_wr, 20);
    chk_int("good_commit", n_commit, 1);
    chk_int("good_err", n_err, 0);

    clr_counts();
    q = mk_good(0); q[0] = 8'h5A;
    frame_tx(q, "bad_hdr");
    chk_int("bad_hdr_writes", n_wr, 0);
    chk_int("bad_hdr_commit", n_commit, 0);
    chk_int("bad_hdr_err", n_err, 1);
    chk_int("bad_hdr_count", int'(bus.err_count), 4);

    clr_counts();
    q = mk_good(0); q[FRAME_N + 1] = 8'h15;
    frame_tx(q, "bad_sum");
    chk_int("bad_sum_writes", n_wr, 20);
    chk_int("bad_sum_commit", n_commit, 0);
    chk_int("bad_sum_err", n_err, 1);

    clr_counts();
    q = mk_good(0); q = q[0:10];
    frame_tx(q, "trunc");
    chk_int("trunc_commit", n_commit, 0);
    chk_int("trunc_err", n_err, 1);
    chk_int("trunc_idle", int'(bus.busy), 0);
    clr_counts();
    frame_tx(mk_good(1), "after_trunc");
    chk_int("after_trunc_commit", n_commit, 1);

    clr_counts();
    q = mk_good(0); q.push_back(8'h77);
    frame_tx(q, "overlen");
    chk_int("overlen_commit", n_commit, 0);
    chk_int("overlen_err", n_err, 1);

    clr_counts();
    q = mk_good(0); q[0] = 8'h00; q = q[0:1];
    for (int i = 0; i < 300; i++) frame_tx(q, "sat");
    chk_int("sat_errs", n_err, 300);
    chk_int("sat_count", int'(bus.err_count), 255);

    // Reset during payload byte 7: outputs must drop without waiting for a clock
    q = mk_good(0);
    cyc(1, 0, 0, 8'h00, "rst_mid");
    send(q[0:7], 0, "rst_mid");
    #2 rst_n = 1'b0;
    #1 check("rst_async", actual(), '0);
    in_frame = 1'b0; frame.delete(); ecnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 8'hA5, "post_rst_idle");
    cyc(0, 1, 0, 8'h00, "post_rst_idle");
    clr_counts();
    frame_tx(mk_good(1), "post_rst");
    chk_int("post_rst_commit", n_commit, 1);
    chk_int("post_rst_writes", n_wr, 20);

    // Random frames: good, bad header, bad sum, truncated, overlength; varied closings
    begin
      bit started = 1'b0;
      for (int f = 0; f < 150; f++) begin
        int kind = $urandom_range(0, 5);
        int mode = $urandom_range(0, 3);
        q = mk_good(1);
        case (kind)
          1: q[0] = q[0] ^ 8'(1 << $urandom_range(0, 7));
          2: q[FRAME_N + 1] = ~q[FRAME_N + 1];
          3: q = q[0:$urandom_range(0, FRAME_N)];
          4: q.push_back(8'($urandom));
          default: ;
        endcase
        if (!started) cyc(1, 0, 0, 8'h00, "rnd");
        started = 1'b0;
        send(q, 2, "rnd");
        case (mode)
          0: cyc(0, 1, 0, 8'h00, "rnd");
          1: cyc(0, 1, 1, 8'($urandom), "rnd");
          2: begin cyc(1, 1, 0, 8'h00, "rnd"); started = 1'b1; end
          default: begin cyc(1, 0, 0, 8'h00, "rnd"); started = 1'b1; end
        endcase
        repeat ($urandom_range(0, 2)) cyc(0, 0, $urandom_range(0, 1), 8'($urandom), "rnd");
      end
      if (started) cyc(0, 1, 0, 8'h00, "rnd");
      cyc(0, 0, 0, 8'h00, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
